// File: rtl/dwt_pkg.sv
// Shared types and widths for the DWT front end: sample/level widths,
// the row reader FSM states and the tagged word carried through the skid buffer.
package dwt_pkg;

    localparam int DWT_DATA_W  = 16;
    localparam int DWT_USEDW_W = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } dwt_rd_state_t;

    typedef struct packed {
        logic [DWT_DATA_W-1:0] data;
        logic                  sop;
        logic                  eop;
        logic                  sof;
        logic                  eof;
    } dwt_word_t;

endpackage

// File: rtl/dwt_skid_buf.sv
// Four-entry circular buffer of tagged words; absorbs the words still in flight
// from the FIFO when the lifting stage stops accepting.
module dwt_skid_buf
    import dwt_pkg::*;
(
    input  logic       clock_i,
    input  logic       sclr_i,
    input  logic       push_i,
    input  dwt_word_t  word_i,
    input  logic       pop_i,
    output dwt_word_t  head_o,
    output logic [2:0] count_o
);

    dwt_word_t  mem_q [4];
    logic [1:0] wrPtr_q;
    logic [1:0] rdPtr_q;
    logic [2:0] count_q;

    always_ff @(posedge clock_i) begin
        if (sclr_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                wrPtr_q <= wrPtr_q + 2'd1;
            end
            if (pop_i) begin
                rdPtr_q <= rdPtr_q + 2'd1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the pointers and count decide what is visible.
    always_ff @(posedge clock_i) begin
        if (push_i) begin
            mem_q[wrPtr_q] <= word_i;
        end
    end

    assign head_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

endmodule

// File: rtl/dwt_fifo_reader.sv
// Row-burst reader for the DWT sample FIFO: waits until a whole row is buffered,
// reads it out through a skid buffer and tags each word with row/frame markers.
module dwt_fifo_reader
    import dwt_pkg::*;
#(
    parameter int DATA_W  = DWT_DATA_W,
    parameter int USEDW_W = DWT_USEDW_W,
    parameter int ROW_LEN = 64,
    parameter int ROWS    = 64
) (
    input  logic               clock,
    input  logic               sclr,
    input  logic [DATA_W-1:0]  fifo_q,
    input  logic               fifo_empty,
    input  logic               fifo_full,
    input  logic [USEDW_W-1:0] fifo_usedw,
    output logic               fifo_rdreq,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sop,
    output logic               out_eop,
    output logic               out_sof,
    output logic               out_eof,
    output logic               busy
);

    localparam int RD_W  = $clog2(ROW_LEN + 1);
    localparam int ROW_W = $clog2(ROWS + 1);
    localparam logic [RD_W-1:0]  RD_LAST   = RD_W'(ROW_LEN - 1);
    localparam logic [RD_W-1:0]  RD_LIMIT  = RD_W'(ROW_LEN);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [USEDW_W:0] LEVEL_MIN = (USEDW_W + 1)'(ROW_LEN);

    dwt_rd_state_t    state_q, state_d;
    logic [RD_W-1:0]  rdCnt_q, rdCnt_d;
    logic [ROW_W-1:0] rowCnt_q, rowCnt_d;
    logic             inflight_q;
    logic [3:0]       tag_q;
    logic             issueSop, issueEop, issueSof, issueEof;
    logic             rdReq, popWord;
    logic [2:0]       bufCount;
    dwt_word_t        pushWord, headWord;

    // Issue decision uses only registered state and fifo_empty, never out_ready.
    always_comb begin
        issueSop = (rdCnt_q == '0);
        issueEop = (rdCnt_q == RD_LAST);
        issueSof = issueSop && (rowCnt_q == '0);
        issueEof = issueEop && (rowCnt_q == ROW_LAST);
        rdReq    = (state_q == BURST) && !fifo_empty
                && ((bufCount + {2'b00, inflight_q}) < 3'd3)
                && (rdCnt_q < RD_LIMIT);
    end

    always_comb begin
        state_d  = state_q;
        rdCnt_d  = rdCnt_q;
        rowCnt_d = rowCnt_q;
        case (state_q)
            IDLE: begin
                if (fifo_full || ({1'b0, fifo_usedw} >= LEVEL_MIN)) begin
                    state_d = BURST;
                end
            end
            BURST: begin
                if (rdReq && issueEop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rdReq) begin
            if (issueEop) begin
                rdCnt_d  = '0;
                rowCnt_d = (rowCnt_q == ROW_LAST) ? '0 : rowCnt_q + 1'b1;
            end else begin
                rdCnt_d = rdCnt_q + 1'b1;
            end
        end
    end

    // Tags are frozen at issue time and paired with fifo_q one cycle later.
    always_ff @(posedge clock) begin
        if (sclr) begin
            state_q    <= IDLE;
            rdCnt_q    <= '0;
            rowCnt_q   <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            rdCnt_q    <= rdCnt_d;
            rowCnt_q   <= rowCnt_d;
            inflight_q <= rdReq;
            if (rdReq) begin
                tag_q <= {issueSop, issueEop, issueSof, issueEof};
            end
        end
    end

    always_comb begin
        pushWord.data = fifo_q;
        pushWord.sop  = tag_q[3];
        pushWord.eop  = tag_q[2];
        pushWord.sof  = tag_q[1];
        pushWord.eof  = tag_q[0];
    end

    assign popWord = out_valid && out_ready;

    dwt_skid_buf u_skid (
        .clock_i (clock),
        .sclr_i  (sclr),
        .push_i  (inflight_q),
        .word_i  (pushWord),
        .pop_i   (popWord),
        .head_o  (headWord),
        .count_o (bufCount)
    );

    assign fifo_rdreq = rdReq;
    assign out_valid  = (bufCount != 3'd0);
    assign out_data   = out_valid ? headWord.data : '0;
    assign out_sop    = out_valid && headWord.sop;
    assign out_eop    = out_valid && headWord.eop;
    assign out_sof    = out_valid && headWord.sof;
    assign out_eof    = out_valid && headWord.eof;
    assign busy       = (state_q == BURST) || out_valid;

endmodule
